// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the SRAM port arbiter: requester IDs, FSM encodings
// and SRAM active-low control levels.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_LDR = 2'd0,
        REQ_SPI = 2'd1,
        REQ_CPU = 2'd2
    } req_id_e;

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_OWN  = 2'b01;
    localparam logic [1:0] ARB_GAP  = 2'b10;

    localparam logic SRAM_ON  = 1'b0;
    localparam logic SRAM_OFF = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: LDR has absolute priority, SPI and CPU share
// the bus round-robin according to rr_ptr.
module arb_pick
    import sram_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_e    rr_ptr,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        if (req[REQ_LDR]) begin
            win = 3'b001;
        end else if (req[REQ_SPI] && req[REQ_CPU]) begin
            win = (rr_ptr == REQ_CPU) ? 3'b100 : 3'b010;
        end else if (req[REQ_SPI]) begin
            win = 3'b010;
        end else if (req[REQ_CPU]) begin
            win = 3'b100;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Three-way req/gnt arbiter for a single-port SRAM with burst limit, one-cycle
// handover gap and read-return routing. Optional perf counters: SRAM_ARB_PERF_CNT_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 16,
    parameter int BURST_CNT_W = 5
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [2:0]              REQ,
    input  logic [2:0]              ACC,
    input  logic [2:0]              WE,
    input  logic [3*ADDR_WIDTH-1:0] ADDR,
    input  logic [3*DATA_WIDTH-1:0] WDATA,
    output logic [2:0]              GNT,
    output logic [2:0]              RVALID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    CEN,
    output logic                    WEN,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [47:0]             PERF_ACC,
    output logic [15:0]             PERF_GAP
`endif
);

    logic [1:0]             state;
    logic [2:0]             win;
    req_id_e                rr_ptr;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] burst_nxt;
    logic [2:0]             acc_hit;
    logic                   acc_ok;
    logic [ADDR_WIDTH-1:0]  own_addr;
    logic [DATA_WIDTH-1:0]  own_wdata;
    logic                   own_we;
    logic                   owner_drop;
    logic                   burst_end;
    logic                   ldr_preempt;
    logic                   own_end;
    logic [2:0]             vld_p1;
    logic [2:0]             vld_p2;

    arb_pick u_arb_pick (
        .req    (REQ),
        .rr_ptr (rr_ptr),
        .win    (win)
    );

    always_comb begin
        acc_hit   = ACC & GNT;
        acc_ok    = |acc_hit;
        own_addr  = '0;
        own_wdata = '0;
        own_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (GNT[i]) begin
                own_addr  = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_wdata = WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                own_we    = WE[i];
            end
        end
        burst_nxt   = burst_cnt + 1'b1;
        owner_drop  = ~|(REQ & GNT);
        burst_end   = acc_ok && (burst_nxt == BURST_CNT_W'(MAX_BURST));
        ldr_preempt = REQ[REQ_LDR] && !GNT[REQ_LDR];
        own_end     = owner_drop || burst_end || ldr_preempt;
    end

    // Arbitration FSM; grant is only ever loaded from the one-hot picker or cleared
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ARB_IDLE;
            GNT       <= 3'b000;
            burst_cnt <= '0;
            rr_ptr    <= REQ_SPI;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|REQ) begin
                        state     <= ARB_OWN;
                        GNT       <= win;
                        burst_cnt <= '0;
                    end
                end
                ARB_OWN: begin
                    if (acc_ok) begin
                        burst_cnt <= burst_nxt;
                    end
                    if (own_end) begin
                        state <= ARB_GAP;
                        GNT   <= 3'b000;
                        if (GNT[REQ_SPI]) begin
                            rr_ptr <= REQ_CPU;
                        end else if (GNT[REQ_CPU]) begin
                            rr_ptr <= REQ_SPI;
                        end
                    end
                end
                ARB_GAP: begin
                    if (|REQ) begin
                        state     <= ARB_OWN;
                        GNT       <= win;
                        burst_cnt <= '0;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    GNT   <= 3'b000;
                end
            endcase
        end
    end

    // p0 -> p1: SRAM command issue, read tag enters return pipeline
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CEN    <= SRAM_OFF;
            WEN    <= SRAM_OFF;
            A      <= '0;
            D      <= '0;
            vld_p1 <= 3'b000;
            vld_p2 <= 3'b000;
            RVALID <= 3'b000;
        end else begin
            vld_p1 <= (acc_ok && !own_we) ? acc_hit : 3'b000;
            vld_p2 <= vld_p1;
            RVALID <= vld_p2;
            if (acc_ok) begin
                CEN <= SRAM_ON;
                WEN <= own_we ? SRAM_ON : SRAM_OFF;
                A   <= own_addr;
                D   <= own_wdata;
            end else begin
                CEN <= SRAM_OFF;
                WEN <= SRAM_OFF;
            end
        end
    end

    // p2 -> out: capture SRAM read data alongside RVALID
    always_ff @(posedge CLK) begin
        if (|vld_p2) begin
            RDATA <= Q;
        end
    end

`ifdef SRAM_ARB_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PERF_ACC <= '0;
            PERF_GAP <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (acc_hit[i]) begin
                    PERF_ACC[i*16 +: 16] <= sat_inc16(PERF_ACC[i*16 +: 16]);
                end
            end
            if (state == ARB_GAP) begin
                PERF_GAP <= sat_inc16(PERF_GAP);
            end
        end
    end
`endif

endmodule
